serial_tx_buffered: RTL and testbench

Parallel-to-serial transmitter with a word queue, programmable bit period and selectable bit order, on a single clock domain.
- Words are pushed into an internal FIFO with `sample` and shifted out on `dout` while `startTx` is high.
- Consecutive queued words go out back-to-back, with no idle gap.
- Sits between a parallel data producer and a single-wire serial sink.

---
 rtl/serial_tx_pkg.sv | 17 +
 rtl/tx_fifo.sv | 63 ++++++
 rtl/serial_tx_buffered.sv | 134 +++++++++++++
 tb/tb_serial_tx_buffered.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the buffered serial transmitter.
package serial_tx_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } tx_state_e;

  // Width needed to count 0..depth queued words.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Word queue feeding the serial shifter; full/empty/level are registered together.
module tx_fifo
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic [LVL_W-1:0] level_nxt;

  // Accept/pop qualification; full is judged before any same-cycle pop.
  always_comb begin
    wr_en     = push && !full;
    rd_en     = pop && !empty;
    level_nxt = level + LVL_W'(wr_en) - LVL_W'(rd_en);
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level_nxt;
      full     <= (level_nxt == LVL_W'(DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= push && full;
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/serial_tx_buffered.sv
// Queued parallel-to-serial transmitter with programmable bit period and bit order.
module serial_tx_buffered
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       sample,
  input  logic                       startTx,
  input  logic                       msbFirst,
  input  logic [DIV_W-1:0]           clkDiv,
  output logic                       dout,
  output logic                       txBusy,
  output logic                       txDone,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       overflow
);

  localparam int unsigned BIT_W = $clog2(WIDTH);

  tx_state_e        state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_W-1:0] div_lat, div_lat_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             msb_lat, msb_lat_nxt;
  logic             dout_nxt, busy_nxt, done_nxt;
  logic             pop_c;
  logic [WIDTH-1:0] head_c;

  tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (sample),
    .din      (dataIn),
    .pop      (pop_c),
    .head_c   (head_c),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Next-state: bit timing, shifting, and word (re)load including back-to-back chaining.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    div_cnt_nxt = div_cnt;
    div_lat_nxt = div_lat;
    bit_cnt_nxt = bit_cnt;
    msb_lat_nxt = msb_lat;
    dout_nxt    = dout;
    busy_nxt    = txBusy;
    done_nxt    = 1'b0;
    pop_c       = 1'b0;

    case (state)
      IDLE: begin
        if (startTx && !empty) pop_c = 1'b1;
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_nxt = div_cnt - DIV_W'(1);
        end else if (bit_cnt != '0) begin
          if (msb_lat) begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            dout_nxt  = shreg[WIDTH-2];
          end else begin
            shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
            dout_nxt  = shreg[1];
          end
          bit_cnt_nxt = bit_cnt - BIT_W'(1);
          div_cnt_nxt = div_lat;
        end else begin
          done_nxt = 1'b1;
          if (startTx && !empty) begin
            pop_c = 1'b1;
          end else begin
            state_nxt = IDLE;
            dout_nxt  = 1'b0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (pop_c) begin
      state_nxt   = SHIFT;
      shreg_nxt   = head_c;
      msb_lat_nxt = msbFirst;
      div_lat_nxt = clkDiv;
      div_cnt_nxt = clkDiv;
      bit_cnt_nxt = BIT_W'(WIDTH - 1);
      dout_nxt    = msbFirst ? head_c[WIDTH-1] : head_c[0];
      busy_nxt    = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      div_lat <= '0;
      bit_cnt <= '0;
      msb_lat <= 1'b0;
      dout    <= 1'b0;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      div_cnt <= div_cnt_nxt;
      div_lat <= div_lat_nxt;
      bit_cnt <= bit_cnt_nxt;
      msb_lat <= msb_lat_nxt;
      dout    <= dout_nxt;
      txBusy  <= busy_nxt;
      txDone  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Directed bench for serial_tx_buffered (WIDTH=8, DEPTH=4).
module tb_serial_tx_buffered;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dataIn;
  logic             sample;
  logic             startTx;
  logic             msbFirst;
  logic [DIV_W-1:0] clkDiv;
  logic             dout;
  logic             txBusy;
  logic             txDone;
  logic             full;
  logic             empty;
  logic [2:0]       level;
  logic             overflow;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_tx_buffered #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dataIn   (dataIn),
    .sample   (sample),
    .startTx  (startTx),
    .msbFirst (msbFirst),
    .clkDiv   (clkDiv),
    .dout     (dout),
    .txBusy   (txBusy),
    .txDone   (txDone),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Single comparison point: counts every vector, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One push strobe; returns at the negedge after the push edge.
  task automatic push_word(input logic [7:0] d);
    sample = 1'b1;
    dataIn = d;
    @(negedge clk);
    sample = 1'b0;
  endtask

  // Starting at the first negedge after the load edge, check every cycle of one word.
  task automatic expect_word(input string tag, input logic [7:0] w, input bit msb,
                             input int div, input bit done_first);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c <= div; c++) begin
        check({tag, "_dout"}, 32'(dout), 32'(msb ? wv[7-i] : wv[i]));
        check({tag, "_busy"}, 32'(txBusy), 32'd1);
        check({tag, "_done"}, 32'(txDone), (i == 0 && c == 0) ? 32'(done_first) : 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    sample   = 1'b0;
    startTx  = 1'b0;
    msbFirst = 1'b1;
    clkDiv   = '0;
    dataIn   = '0;

    // Reset state
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(txBusy), 32'd0);
    check("rst_done", 32'(txDone), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MSB first, one bit per cycle
    msbFirst = 1'b1;
    clkDiv   = 8'd0;
    push_word(8'hA5);
    check("t1_level", 32'(level), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    startTx = 1'b1;
    @(negedge clk);
    expect_word("t1", 8'hA5, 1'b1, 0, 1'b0);
    check("t1_end_done", 32'(txDone), 32'd1);
    check("t1_end_busy", 32'(txBusy), 32'd0);
    check("t1_end_dout", 32'(dout), 32'd0);
    check("t1_end_empty", 32'(empty), 32'd1);
    startTx = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", 32'(txDone), 32'd0);

    // 2: LSB first, three cycles per bit
    msbFirst = 1'b0;
    clkDiv   = 8'd2;
    push_word(8'h01);
    startTx = 1'b1;
    @(negedge clk);
    expect_word("t2", 8'h01, 1'b0, 2, 1'b0);
    check("t2_end_done", 32'(txDone), 32'd1);
    check("t2_end_busy", 32'(txBusy), 32'd0);
    check("t2_end_dout", 32'(dout), 32'd0);
    startTx = 1'b0;
    @(negedge clk);

    // 3: back-to-back words without a gap
    msbFirst = 1'b1;
    clkDiv   = 8'd0;
    push_word(8'hFF);
    push_word(8'h00);
    check("t3_level", 32'(level), 32'd2);
    startTx = 1'b1;
    @(negedge clk);
    expect_word("t3a", 8'hFF, 1'b1, 0, 1'b0);
    expect_word("t3b", 8'h00, 1'b1, 0, 1'b1);
    check("t3_end_done", 32'(txDone), 32'd1);
    check("t3_end_busy", 32'(txBusy), 32'd0);
    check("t3_end_empty", 32'(empty), 32'd1);
    startTx = 1'b0;
    @(negedge clk);

    // 4: overflow on the fifth push
    for (int k = 0; k < 5; k++) begin
      push_word(8'((k + 1) * 17));
      if (k < 4) begin
        check("t4_level", 32'(level), 32'(k + 1));
        check("t4_full", 32'(full), (k == 3) ? 32'd1 : 32'd0);
        check("t4_ovf_lo", 32'(overflow), 32'd0);
      end else begin
        check("t4_ovf_hi", 32'(overflow), 32'd1);
        check("t4_level_full", 32'(level), 32'd4);
        check("t4_full_hold", 32'(full), 32'd1);
      end
    end
    @(negedge clk);
    check("t4_ovf_pulse", 32'(overflow), 32'd0);
    check("t4_level_kept", 32'(level), 32'd4);
    startTx = 1'b1;
    @(negedge clk);
    expect_word("t4w1", 8'h11, 1'b1, 0, 1'b0);
    expect_word("t4w2", 8'h22, 1'b1, 0, 1'b1);
    expect_word("t4w3", 8'h33, 1'b1, 0, 1'b1);
    expect_word("t4w4", 8'h44, 1'b1, 0, 1'b1);
    check("t4_end_done", 32'(txDone), 32'd1);
    check("t4_end_busy", 32'(txBusy), 32'd0);
    check("t4_end_empty", 32'(empty), 32'd1);
    check("t4_end_level", 32'(level), 32'd0);
    startTx = 1'b0;
    @(negedge clk);

    // 5: asynchronous reset in the middle of a word
    push_word(8'hF0);
    push_word(8'h3C);
    push_word(8'h66);
    startTx = 1'b1;
    @(negedge clk);
    check("t5_level", 32'(level), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("t5_dout", 32'(dout), 32'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("t5_rst_dout", 32'(dout), 32'd0);
    check("t5_rst_busy", 32'(txBusy), 32'd0);
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_empty", 32'(empty), 32'd1);
    check("t5_rst_full", 32'(full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t5_post_dout", 32'(dout), 32'd0);
      check("t5_post_busy", 32'(txBusy), 32'd0);
      check("t5_post_empty", 32'(empty), 32'd1);
    end
    startTx = 1'b0;
    @(negedge clk);

    // 6: startTx dropped mid-word, then resumed
    msbFirst = 1'b0;
    clkDiv   = 8'd1;
    push_word(8'hA1);
    push_word(8'hB2);
    push_word(8'hC3);
    startTx = 1'b1;
    @(negedge clk);
    startTx  = 1'b0;
    clkDiv   = 8'd5;
    msbFirst = 1'b1;
    expect_word("t6a", 8'hA1, 1'b0, 1, 1'b0);
    check("t6_end_done", 32'(txDone), 32'd1);
    check("t6_end_busy", 32'(txBusy), 32'd0);
    check("t6_end_dout", 32'(dout), 32'd0);
    check("t6_level", 32'(level), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_hold_busy", 32'(txBusy), 32'd0);
      check("t6_hold_level", 32'(level), 32'd2);
    end
    clkDiv  = 8'd0;
    startTx = 1'b1;
    @(negedge clk);
    expect_word("t6b", 8'hB2, 1'b1, 0, 1'b0);
    expect_word("t6c", 8'hC3, 1'b1, 0, 1'b1);
    check("t6_fin_done", 32'(txDone), 32'd1);
    check("t6_fin_busy", 32'(txBusy), 32'd0);
    check("t6_fin_empty", 32'(empty), 32'd1);
    startTx = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
